instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the lab decoder.
- Holds a small loadable instruction memory and steps a program counter through a programmed range.
- Presents one 32-bit instruction per cycle on the decoder's Instruction input, qualified by Valid.
- The downstream stage can freeze issue with Stall; Done flags the end of the program.

Parameters:
DEPTH, 16, number of 32-bit instruction words; must be a power of two
ADDR_W, 4, address width, equal to log2(DEPTH)
DATA_W, 32, instruction width

Ports:
Clk  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Load_En  input  1  memory write strobe, sampled on the rising edge
Load_Addr  input  ADDR_W  memory write address
Load_Data  input  DATA_W  memory write data
Start  input  1  begin fetching at address 0, sampled on the rising edge
Last  input  ADDR_W  address of the final instruction; latched when Start is accepted
Stall  input  1  downstream hold request; freezes PC and outputs
Instruction  output  DATA_W  registered instruction word, to the decoder
Valid  output  1  Instruction holds a newly issued word
Issue_PC  output  ADDR_W  address of the word currently on Instruction
Done  output  1  high while the FSM is in DONE
Busy  output  1  high while the FSM is in RUN

Behaviour:
- Reset (Reset=0, asynchronous, no clock needed), outputs take these values:
  - State=IDLE, internal pc=0, end register=0.
  - Instruction=0, Valid=0, Issue_PC=0, Done=0, Busy=0.
- Reset does not clear memory contents.
- Reset asserted mid-RUN aborts immediately with the same values; a new Start is then required.
- Memory write:
  - On a rising edge with Load_En=1 and state IDLE or DONE, mem[Load_Addr] <= Load_Data.
  - Load_En is ignored while in RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1 -> pc<=0, end<=Last, go to RUN.
  - Instruction, Valid and Issue_PC hold their values.
- RUN, edge with Stall=0:
  - Instruction<=mem[pc], Issue_PC<=pc, Valid<=1.
  - If pc==end, go to DONE; otherwise pc<=pc+1.
- RUN, edge with Stall=1:
  - pc, Instruction, Issue_PC, Valid and state are all held unchanged.
- DONE:
  - Edge with Stall=0 -> Valid<=0; Instruction and Issue_PC keep their last values.
  - Edge with Stall=1 -> Valid held.
  - Start=1 -> pc<=0, end<=Last, go to RUN; Valid follows the Stall rule above in that same edge.
- Start while in RUN is ignored.
- Latency:
  - Start accepted at edge N -> mem[0] appears on Instruction with Valid=1 after edge N+1 (assuming no stall).
  - Thereafter one word per non-stalled edge.
- Count: exactly end+1 words are issued per run. Last=0 issues only mem[0].
- pc never wraps: the end comparison stops it. Last=DEPTH-1 issues the whole memory.
- Simultaneous Load_En and Start in IDLE/DONE:
  - The write completes at that edge.
  - The first fetch happens at the following edge, so it sees the new data even if Load_Addr=0.
- Stall has no effect in IDLE.
- Done=1 exactly while state==DONE; Busy=1 exactly while state==RUN.
- Timing: memory is read combinationally from pc and the output is registered; no combinational path from any input to any output.

Test Plan:
- Reset values: hold Reset=0 then release -> Instruction=0, Valid=0, Issue_PC=0, Done=0, Busy=0. Assert Reset=0 mid-RUN between clock edges -> all outputs clear immediately, without waiting for an edge.
- Basic run:
  - Load mem[0..3] = 0x80000300, 0x80010200, 0x80020100, 0x80030000; Start with Last=3.
  - Required: on the 4 consecutive edges after Start, Instruction shows these words in order with Valid=1 and Issue_PC=0,1,2,3.
  - Done=1 from the 4th issue; Valid=0 one edge later.
- Stall:
  - Load 0x40070100, 0x40060000, 0x40050200 at 0..2; Start with Last=2; hold Stall=1 for 3 cycles while Issue_PC=1.
  - Required: Instruction stays 0x40060000 with Valid=1 for those cycles, then 0x40050200 on the first non-stalled edge.
- Single instruction: Last=0, mem[0]=0x40040300 -> exactly one Valid pulse, then Done=1.
- Full range and ignored inputs:
  - Last=15 -> 16 words issued, Issue_PC stops at 15 with no wrap.
  - Load_En and Start pulsed during RUN -> memory unchanged and the sequence is not restarted.
- Restart from DONE: in one cycle, Load_En=1 with Load_Addr=0, Load_Data=0x80000000, and Start=1 -> the first issued word is 0x80000000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable instruction memory plus a PC that walks
// 0..Last and issues one registered word per non-stalled cycle to the decoder.
module instr_fetch_unit #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load_En,
    input  logic [ADDR_W-1:0] Load_Addr,
    input  logic [DATA_W-1:0] Load_Data,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Last,
    input  logic              Stall,
    output logic [DATA_W-1:0] Instruction,
    output logic              Valid,
    output logic [ADDR_W-1:0] Issue_PC,
    output logic              Done,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   end_r;
    logic [DATA_W-1:0]   instr_r;
    logic                valid_r;
    logic [ADDR_W-1:0]   issue_pc_r;
    logic                done_r;
    logic                busy_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                wr_en_s;
    logic [ADDR_W-1:0]   pc_next_s;

    assign wr_en_s   = Load_En && (state_r != RUN);
    assign pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            mem_r[Load_Addr] <= Load_Data;
        end
    end

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= IDLE;
            pc_r       <= {ADDR_W{1'b0}};
            end_r      <= {ADDR_W{1'b0}};
            instr_r    <= {DATA_W{1'b0}};
            valid_r    <= 1'b0;
            issue_pc_r <= {ADDR_W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        pc_r    <= {ADDR_W{1'b0}};
                        end_r   <= Last;
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        instr_r    <= mem_r[pc_r];
                        issue_pc_r <= pc_r;
                        valid_r    <= 1'b1;
                        // The end compare, not wraparound, terminates the walk.
                        if (pc_r == end_r) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            pc_r <= pc_next_s;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (!Stall) begin
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                    if (Start) begin
                        pc_r    <= {ADDR_W{1'b0}};
                        end_r   <= Last;
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Instruction = instr_r;
    assign Valid       = valid_r;
    assign Issue_PC    = issue_pc_r;
    assign Done        = done_r;
    assign Busy        = busy_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit: table of per-cycle inputs and
// expected outputs, plus hand-built sequences for full-range, restart and reset.
module tb_instr_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Load_En;
    logic [3:0]  Load_Addr;
    logic [31:0] Load_Data;
    logic        Start;
    logic [3:0]  Last;
    logic        Stall;
    logic [31:0] Instruction;
    logic        Valid;
    logic [3:0]  Issue_PC;
    logic        Done;
    logic        Busy;

    int n_vec;
    int n_err;

    typedef struct {
        logic        load_en;
        logic [3:0]  load_addr;
        logic [31:0] load_data;
        logic        start;
        logic [3:0]  last;
        logic        stall;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic [3:0]  exp_pc;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [26];

    instr_fetch_unit #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Load_En     (Load_En),
        .Load_Addr   (Load_Addr),
        .Load_Data   (Load_Data),
        .Start       (Start),
        .Last        (Last),
        .Stall       (Stall),
        .Instruction (Instruction),
        .Valid       (Valid),
        .Issue_PC    (Issue_PC),
        .Done        (Done),
        .Busy        (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t v(input logic le, input logic [3:0] la, input logic [31:0] ld,
                               input logic st, input logic [3:0] lst, input logic sl,
                               input logic [31:0] ei, input logic ev, input logic [3:0] ep,
                               input logic ed, input logic eb);
        vec_t r;
        r.load_en = le; r.load_addr = la; r.load_data = ld;
        r.start = st; r.last = lst; r.stall = sl;
        r.exp_instr = ei; r.exp_valid = ev; r.exp_pc = ep;
        r.exp_done = ed; r.exp_busy = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] ei, input logic ev,
                         input logic [3:0] ep, input logic ed, input logic eb);
        n_vec++;
        if (Instruction !== ei || Valid !== ev || Issue_PC !== ep || Done !== ed || Busy !== eb) begin
            n_err++;
            $display("FAIL %s: got instr=%h valid=%b pc=%0d done=%b busy=%b, want instr=%h valid=%b pc=%0d done=%b busy=%b",
                     name, Instruction, Valid, Issue_PC, Done, Busy, ei, ev, ep, ed, eb);
        end
    endtask

    // Drive one vector, clock it, then compare on the falling edge.
    task automatic apply(input vec_t t, input string name);
        Load_En = t.load_en; Load_Addr = t.load_addr; Load_Data = t.load_data;
        Start = t.start; Last = t.last; Stall = t.stall;
        @(posedge Clk);
        @(negedge Clk);
        check(name, t.exp_instr, t.exp_valid, t.exp_pc, t.exp_done, t.exp_busy);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b0; Load_En = 1'b0; Load_Addr = 4'd0; Load_Data = 32'd0;
        Start = 1'b0; Last = 4'd0; Stall = 1'b0;

        // Basic run
        tbl[0]  = v(1'b1, 4'd0, 32'h80000300, 1'b0, 4'd0, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1'b0);
        tbl[1]  = v(1'b1, 4'd1, 32'h80010200, 1'b0, 4'd0, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1'b0);
        tbl[2]  = v(1'b1, 4'd2, 32'h80020100, 1'b0, 4'd0, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1'b0);
        tbl[3]  = v(1'b1, 4'd3, 32'h80030000, 1'b0, 4'd0, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1'b0);
        tbl[4]  = v(1'b0, 4'd0, 32'h0,        1'b1, 4'd3, 1'b0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1'b1);
        tbl[5]  = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h80000300, 1'b1, 4'd0, 1'b0, 1'b1);
        tbl[6]  = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h80010200, 1'b1, 4'd1, 1'b0, 1'b1);
        tbl[7]  = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h80020100, 1'b1, 4'd2, 1'b0, 1'b1);
        tbl[8]  = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h80030000, 1'b1, 4'd3, 1'b1, 1'b0);
        tbl[9]  = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h80030000, 1'b0, 4'd3, 1'b1, 1'b0);
        // Stall run, loaded from DONE
        tbl[10] = v(1'b1, 4'd0, 32'h40070100, 1'b0, 4'd0, 1'b0, 32'h80030000, 1'b0, 4'd3, 1'b1, 1'b0);
        tbl[11] = v(1'b1, 4'd1, 32'h40060000, 1'b0, 4'd0, 1'b0, 32'h80030000, 1'b0, 4'd3, 1'b1, 1'b0);
        tbl[12] = v(1'b1, 4'd2, 32'h40050200, 1'b0, 4'd0, 1'b0, 32'h80030000, 1'b0, 4'd3, 1'b1, 1'b0);
        tbl[13] = v(1'b0, 4'd0, 32'h0,        1'b1, 4'd2, 1'b0, 32'h80030000, 1'b0, 4'd3, 1'b0, 1'b1);
        tbl[14] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h40070100, 1'b1, 4'd0, 1'b0, 1'b1);
        tbl[15] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h40060000, 1'b1, 4'd1, 1'b0, 1'b1);
        tbl[16] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h40060000, 1'b1, 4'd1, 1'b0, 1'b1);
        tbl[17] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h40060000, 1'b1, 4'd1, 1'b0, 1'b1);
        tbl[18] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h40060000, 1'b1, 4'd1, 1'b0, 1'b1);
        tbl[19] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h40050200, 1'b1, 4'd2, 1'b1, 1'b0);
        tbl[20] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h40050200, 1'b1, 4'd2, 1'b1, 1'b0);
        tbl[21] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h40050200, 1'b0, 4'd2, 1'b1, 1'b0);
        // Single instruction
        tbl[22] = v(1'b1, 4'd0, 32'h40040300, 1'b0, 4'd0, 1'b0, 32'h40050200, 1'b0, 4'd2, 1'b1, 1'b0);
        tbl[23] = v(1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b0, 32'h40050200, 1'b0, 4'd2, 1'b0, 1'b1);
        tbl[24] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h40040300, 1'b1, 4'd0, 1'b1, 1'b0);
        tbl[25] = v(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h40040300, 1'b0, 4'd0, 1'b1, 1'b0);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("in_reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("after_reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Full range: load 16 words while in DONE, then issue all of them.
        for (int k = 0; k < 16; k++) begin
            apply(v(1'b1, 4'(k), 32'hA0000000 | 32'(k), 1'b0, 4'd0, 1'b0,
                    32'h40040300, 1'b0, 4'd0, 1'b1, 1'b0), $sformatf("full_load[%0d]", k));
        end
        apply(v(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 1'b0, 32'h40040300, 1'b0, 4'd0, 1'b0, 1'b1), "full_start");
        for (int k = 0; k < 16; k++) begin
            // Load_En and Start pulsed mid-run must be ignored.
            if (k == 5) begin
                apply(v(1'b1, 4'd7, 32'hDEADBEEF, 1'b1, 4'd2, 1'b0,
                        32'hA0000000 | 32'(k), 1'b1, 4'(k), 1'b0, 1'b1), "full_ignored");
            end else begin
                apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0,
                        32'hA0000000 | 32'(k), 1'b1, 4'(k), (k == 15), (k != 15)),
                      $sformatf("full_issue[%0d]", k));
            end
        end
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'hA000000F, 1'b0, 4'd15, 1'b1, 1'b0), "full_end");

        // Restart from DONE with a simultaneous write to address 0.
        apply(v(1'b1, 4'd0, 32'h80000000, 1'b1, 4'd1, 1'b0, 32'hA000000F, 1'b0, 4'd15, 1'b0, 1'b1), "restart");
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h80000000, 1'b1, 4'd0, 1'b0, 1'b1), "restart_w0");
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'hA0000001, 1'b1, 4'd1, 1'b1, 1'b0), "restart_w1");

        // Asynchronous reset mid-run, between clock edges.
        apply(v(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 1'b0, 32'hA0000001, 1'b0, 4'd1, 1'b0, 1'b1), "pre_rst_start");
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h80000000, 1'b1, 4'd0, 1'b0, 1'b1), "pre_rst_w0");
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'hA0000001, 1'b1, 4'd1, 1'b0, 1'b1), "pre_rst_w1");
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0), "idle_stall");
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0), "idle_no_start");
        // Memory survives reset.
        apply(v(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1), "post_rst_start");
        apply(v(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h80000000, 1'b1, 4'd0, 1'b1, 1'b0), "post_rst_w0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
